// File: rtl/ni_route_checker.sv
// rtl/ni_route_checker.sv - ejection-port route checker: forwards packets addressed here, drops and counts the rest
module ni_route_checker #(
    parameter int EAw   = 3,
    parameter int DSTPw = 4,
    parameter int Fpay  = 32,
    parameter int CNTw  = 16,
    localparam int Fw   = Fpay + 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [EAw-1:0]  my_e_addr,
    input  logic            flit_in_wr,
    input  logic [Fw-1:0]   flit_in,
    output logic            flit_in_ready,
    output logic            flit_out_wr,
    output logic [Fw-1:0]   flit_out,
    input  logic            flit_out_ready,
    output logic [EAw-1:0]  src_e_addr_o,
    output logic [EAw-1:0]  bad_dest_o,
    output logic            err_misroute,
    output logic            err_frame,
    output logic [CNTw-1:0] pkt_ok_cnt,
    output logic [CNTw-1:0] misroute_cnt,
    output logic [CNTw-1:0] frame_err_cnt
);

    localparam int HDRw = 2 * EAw + DSTPw;
    localparam logic [CNTw-1:0] CNT_ONE = {{(CNTw-1){1'b0}}, 1'b1};

    generate
        if (HDRw > Fpay) begin : g_layout_check
            $error("header fields do not fit in the flit payload");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t         state_q, state_d;
    logic           accept, hdr, tail, dest_match;
    logic           fwd, good_hdr, misroute, frame, pkt_done;
    logic [EAw-1:0] dest, src;

    assign hdr        = flit_in[Fw-1];
    assign tail       = flit_in[Fw-2];
    assign dest       = flit_in[EAw-1:0];
    assign src        = flit_in[2*EAw-1:EAw];
    assign dest_match = (dest == my_e_addr);

    // Drops also wait on backpressure so flits are always consumed in order.
    assign flit_in_ready = !flit_out_wr || flit_out_ready;
    assign accept        = flit_in_wr && flit_in_ready;

    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        good_hdr = 1'b0;
        misroute = 1'b0;
        frame    = 1'b0;
        pkt_done = 1'b0;
        if (accept) begin
            if (hdr) begin
                // A header outside IDLE truncates the current packet but is still evaluated.
                frame = (state_q != IDLE);
                if (dest_match) begin
                    fwd      = 1'b1;
                    good_hdr = 1'b1;
                    pkt_done = tail;
                    state_d  = tail ? IDLE : BODY;
                end else begin
                    misroute = 1'b1;
                    state_d  = tail ? IDLE : DROP;
                end
            end else begin
                case (state_q)
                    IDLE: frame = 1'b1;
                    BODY: begin
                        fwd      = 1'b1;
                        pkt_done = tail;
                        if (tail) state_d = IDLE;
                    end
                    DROP: if (tail) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_out_wr   <= 1'b0;
            flit_out      <= '0;
            src_e_addr_o  <= '0;
            bad_dest_o    <= '0;
            err_misroute  <= 1'b0;
            err_frame     <= 1'b0;
            pkt_ok_cnt    <= '0;
            misroute_cnt  <= '0;
            frame_err_cnt <= '0;
        end else begin
            if (accept) begin
                flit_out_wr <= fwd;
                if (fwd) flit_out <= flit_in;
            end else if (flit_out_ready) begin
                flit_out_wr <= 1'b0;
            end
            err_misroute <= misroute;
            err_frame    <= frame;
            if (good_hdr) src_e_addr_o <= src;
            if (misroute) bad_dest_o   <= dest;
            if (pkt_done && pkt_ok_cnt != '1)    pkt_ok_cnt    <= pkt_ok_cnt + CNT_ONE;
            if (misroute && misroute_cnt != '1)  misroute_cnt  <= misroute_cnt + CNT_ONE;
            if (frame && frame_err_cnt != '1)    frame_err_cnt <= frame_err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ni_route_checker.sv
// tb/tb_ni_route_checker.sv - directed bench for ni_route_checker with a packet-level reference model
module tb_ni_route_checker;

    localparam int EAW  = 3;
    localparam int DSTPW = 4;
    localparam int FPAY = 32;
    localparam int CNTW = 16;
    localparam int FW   = FPAY + 2;
    localparam logic [EAW-1:0] MY = 3'd5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [EAW-1:0]  my_e_addr = MY;
    logic            flit_in_wr = 1'b0;
    logic [FW-1:0]   flit_in = '0;
    logic            flit_out_ready = 1'b1;

    logic            flit_in_ready, flit_out_wr, err_misroute, err_frame;
    logic [FW-1:0]   flit_out;
    logic [EAW-1:0]  src_e_addr_o, bad_dest_o;
    logic [CNTW-1:0] pkt_ok_cnt, misroute_cnt, frame_err_cnt;

    logic            s_in_ready, s_out_wr, s_err_mr, s_err_fr;
    logic [FW-1:0]   s_flit_out;
    logic [EAW-1:0]  s_src, s_bad;
    logic [1:0]      s_ok_cnt, s_mr_cnt, s_fe_cnt;

    ni_route_checker #(.EAw(EAW), .DSTPw(DSTPW), .Fpay(FPAY), .CNTw(CNTW)) dut (
        .clk(clk), .reset(reset), .my_e_addr(my_e_addr),
        .flit_in_wr(flit_in_wr), .flit_in(flit_in), .flit_in_ready(flit_in_ready),
        .flit_out_wr(flit_out_wr), .flit_out(flit_out), .flit_out_ready(flit_out_ready),
        .src_e_addr_o(src_e_addr_o), .bad_dest_o(bad_dest_o),
        .err_misroute(err_misroute), .err_frame(err_frame),
        .pkt_ok_cnt(pkt_ok_cnt), .misroute_cnt(misroute_cnt), .frame_err_cnt(frame_err_cnt)
    );

    ni_route_checker #(.EAw(EAW), .DSTPw(DSTPW), .Fpay(FPAY), .CNTw(2)) u_sat (
        .clk(clk), .reset(reset), .my_e_addr(my_e_addr),
        .flit_in_wr(flit_in_wr), .flit_in(flit_in), .flit_in_ready(s_in_ready),
        .flit_out_wr(s_out_wr), .flit_out(s_flit_out), .flit_out_ready(flit_out_ready),
        .src_e_addr_o(s_src), .bad_dest_o(s_bad),
        .err_misroute(s_err_mr), .err_frame(s_err_fr),
        .pkt_ok_cnt(s_ok_cnt), .misroute_cnt(s_mr_cnt), .frame_err_cnt(s_fe_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: packet verdict (0 none, 1 delivering, 2 discarding) and unbounded event counts.
    logic           model_valid = 1'b0;
    logic           m_wr = 1'b0;
    logic [FW-1:0]  m_flit = '0;
    logic [EAW-1:0] m_src = '0, m_bad = '0;
    logic           m_em = 1'b0, m_ef = 1'b0;
    int             m_ok = 0, m_mr = 0, m_fe = 0, m_mode = 0;

    function automatic int sat(input int c, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (c > lim) ? lim : c;
    endfunction

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] mk_hdr(input logic tl, input logic [EAW-1:0] d,
                                             input logic [EAW-1:0] s, input logic [DSTPW-1:0] dp);
        logic [FPAY-1:0] p;
        p = 32'hA5C3_0000;
        p[EAW-1:0]               = d;
        p[2*EAW-1:EAW]           = s;
        p[2*EAW+DSTPW-1:2*EAW]   = dp;
        return {1'b1, tl, p};
    endfunction

    function automatic logic [FW-1:0] mk_body(input logic tl, input logic [FPAY-1:0] data);
        return {1'b0, tl, data};
    endfunction

    task automatic model_update(input logic r, input logic w, input logic [FW-1:0] f, input logic rdy);
        logic acc, fwd, is_hdr, is_tail;
        logic [EAW-1:0] d;
        model_valid = 1'b1;
        if (r) begin
            m_wr = 1'b0; m_flit = '0; m_src = '0; m_bad = '0; m_em = 1'b0; m_ef = 1'b0;
            m_ok = 0; m_mr = 0; m_fe = 0; m_mode = 0;
        end else begin
            acc = w && (!m_wr || rdy);
            is_hdr = f[FW-1];
            is_tail = f[FW-2];
            d = f[EAW-1:0];
            m_em = 1'b0; m_ef = 1'b0; fwd = 1'b0;
            if (acc) begin
                if (is_hdr) begin
                    if (m_mode != 0) begin m_ef = 1'b1; m_fe++; end
                    if (d == MY) begin
                        fwd = 1'b1;
                        m_src = f[2*EAW-1:EAW];
                        if (is_tail) m_ok++;
                        m_mode = is_tail ? 0 : 1;
                    end else begin
                        m_em = 1'b1; m_bad = d; m_mr++;
                        m_mode = is_tail ? 0 : 2;
                    end
                end else if (m_mode == 0) begin
                    m_ef = 1'b1; m_fe++;
                end else begin
                    fwd = (m_mode == 1);
                    if (is_tail) begin
                        if (m_mode == 1) m_ok++;
                        m_mode = 0;
                    end
                end
                m_wr = fwd;
                if (fwd) m_flit = f;
            end else if (rdy) begin
                m_wr = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [FW-1:0] f, input logic rdy);
        reset = r; flit_in_wr = w; flit_in = f; flit_out_ready = rdy;
        @(posedge clk);
        model_update(r, w, f, rdy);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("flit_in_ready", flit_in_ready, !m_wr || flit_out_ready);
            chk("flit_out_wr", flit_out_wr, m_wr);
            if (m_wr) chk("flit_out", flit_out, m_flit);
            chk("src_e_addr_o", src_e_addr_o, m_src);
            chk("bad_dest_o", bad_dest_o, m_bad);
            chk("err_misroute", err_misroute, m_em);
            chk("err_frame", err_frame, m_ef);
            chk("pkt_ok_cnt", pkt_ok_cnt, sat(m_ok, CNTW));
            chk("misroute_cnt", misroute_cnt, sat(m_mr, CNTW));
            chk("frame_err_cnt", frame_err_cnt, sat(m_fe, CNTW));
            chk("sat_pkt_ok_cnt", s_ok_cnt, sat(m_ok, 2));
            chk("sat_misroute_cnt", s_mr_cnt, sat(m_mr, 2));
            chk("sat_frame_err_cnt", s_fe_cnt, sat(m_fe, 2));
        end
    end

    initial begin
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("lit_reset_ok_cnt", pkt_ok_cnt, 0);
        chk("lit_reset_out_wr", flit_out_wr, 0);
        chk("lit_reset_in_ready", flit_in_ready, 1);
        idle(1);

        // good 3-flit packet
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd5, 3'd2, 4'h3), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h1111_0001), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b1, 32'h1111_0002), 1'b1);
        chk("lit_good_ok_cnt", pkt_ok_cnt, 1);
        chk("lit_good_src", src_e_addr_o, 2);
        idle(2);

        // misrouted 4-flit packet, then a good single-flit packet
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd3, 3'd1, 4'h9), 1'b1);
        chk("lit_mr_pulse", err_misroute, 1);
        chk("lit_mr_bad_dest", bad_dest_o, 3);
        chk("lit_mr_cnt", misroute_cnt, 1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h2222_0001), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h2222_0002), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b1, 32'h2222_0003), 1'b1);
        step(1'b0, 1'b1, mk_hdr(1'b1, 3'd5, 3'd6, 4'h1), 1'b1);
        idle(2);

        // body flit in IDLE, then a header truncating a good packet
        step(1'b0, 1'b1, mk_body(1'b0, 32'h3333_0001), 1'b1);
        chk("lit_frame_pulse", err_frame, 1);
        chk("lit_frame_cnt", frame_err_cnt, 1);
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd5, 3'd1, 4'h2), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h3333_0002), 1'b1);
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd5, 3'd4, 4'h4), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h3333_0003), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b1, 32'h3333_0004), 1'b1);
        idle(1);

        // backpressure for 5 cycles mid-packet
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd5, 3'd3, 4'h5), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h4444_0001), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, mk_body(1'b0, 32'h4444_0002), 1'b0);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h4444_0002), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b1, 32'h4444_0003), 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, mk_hdr(1'b1, 3'd5, 3'd0, 4'h6), 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        idle(2);

        // truncation followed by a misrouted single-flit header
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd5, 3'd2, 4'h7), 1'b1);
        step(1'b0, 1'b1, mk_hdr(1'b1, 3'd0, 3'd2, 4'h7), 1'b1);
        chk("lit_both_frame", err_frame, 1);
        chk("lit_both_mr", err_misroute, 1);
        idle(1);

        // header arriving while discarding
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd1, 3'd2, 4'h8), 1'b1);
        step(1'b0, 1'b1, mk_body(1'b0, 32'h5555_0001), 1'b1);
        step(1'b0, 1'b1, mk_hdr(1'b1, 3'd5, 3'd7, 4'h8), 1'b1);
        idle(2);

        // five misrouted single-flit packets saturate the narrow counters
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, mk_hdr(1'b1, 3'd6, 3'(i), 4'hA), 1'b1);
        idle(1);
        chk("lit_sat_mr_cnt", s_mr_cnt, 3);
        chk("lit_wide_mr_cnt", misroute_cnt, 8);

        // reset after the first of three flits
        step(1'b0, 1'b1, mk_hdr(1'b0, 3'd5, 3'd4, 4'hB), 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        chk("lit_midrst_out_wr", flit_out_wr, 0);
        chk("lit_midrst_ok_cnt", pkt_ok_cnt, 0);
        chk("lit_midrst_src", src_e_addr_o, 0);
        step(1'b0, 1'b1, mk_hdr(1'b1, 3'd5, 3'd3, 4'hC), 1'b1);
        idle(2);
        chk("lit_after_rst_ok", pkt_ok_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
